// File: rtl/atomic_unit.sv
// atomic_unit: RV32A sequencer running LR/SC and AMO load-modify-store over the data-memory port,
// holding the LR/SC reservation and returning rd with a one-cycle done pulse.
module atomic_unit (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_req,
    input  logic [4:0]  i_funct5,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_rs2,
    input  logic        i_inval,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_rd_data,
    output logic        o_misaligned,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);
    localparam int XLEN = 32;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_OR   = 5'b01000;
    localparam logic [4:0] F_AND  = 5'b01100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MAX  = 5'b10100;
    localparam logic [4:0] F_MINU = 5'b11000;
    localparam logic [4:0] F_MAXU = 5'b11100;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [4:0]        funct5_q, funct5_d;
    logic [XLEN-1:2]   addr_q, addr_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              misal_q, misal_d;
    logic              res_valid_q, res_valid_d;
    logic [XLEN-1:2]   res_addr_q, res_addr_d;
    logic [XLEN-1:0]   alu;
    logic              sc_ok;

    // Modify step: s1 = rs2, s2 = loaded word; unknown encodings behave as SWAP.
    always_comb begin
        case (funct5_q)
            F_ADD:   alu = rs2_q + i_mem_rdata;
            F_XOR:   alu = rs2_q ^ i_mem_rdata;
            F_AND:   alu = rs2_q & i_mem_rdata;
            F_OR:    alu = rs2_q | i_mem_rdata;
            F_MIN:   alu = ($signed(rs2_q) < $signed(i_mem_rdata)) ? rs2_q : i_mem_rdata;
            F_MAX:   alu = ($signed(rs2_q) > $signed(i_mem_rdata)) ? rs2_q : i_mem_rdata;
            F_MINU:  alu = (rs2_q < i_mem_rdata) ? rs2_q : i_mem_rdata;
            F_MAXU:  alu = (rs2_q > i_mem_rdata) ? rs2_q : i_mem_rdata;
            default: alu = rs2_q;
        endcase
    end

    assign sc_ok = res_valid_q && !i_inval && (res_addr_q == i_addr[XLEN-1:2]);

    always_comb begin
        state_d     = state_q;
        funct5_d    = funct5_q;
        addr_d      = addr_q;
        rs2_d       = rs2_q;
        wdata_d     = wdata_q;
        result_d    = result_q;
        misal_d     = misal_q;
        res_valid_d = res_valid_q;
        res_addr_d  = res_addr_q;
        case (state_q)
            IDLE: if (i_req) begin
                funct5_d = i_funct5;
                addr_d   = i_addr[XLEN-1:2];
                rs2_d    = i_rs2;
                misal_d  = i_addr[1:0] != 2'b00;
                result_d = '0;
                if (i_addr[1:0] != 2'b00) begin
                    state_d = DONE;
                end else if (i_funct5 == F_SC) begin
                    res_valid_d = 1'b0;
                    state_d     = sc_ok ? WRITE : DONE;
                    result_d    = {{(XLEN-1){1'b0}}, !sc_ok};
                    wdata_d     = sc_ok ? i_rs2 : wdata_q;
                end else begin
                    state_d = READ;
                end
            end
            READ: if (i_mem_ack) begin
                result_d = i_mem_rdata;
                if (funct5_q == F_LR) begin
                    res_valid_d = 1'b1;
                    res_addr_d  = addr_q;
                    state_d     = DONE;
                end else begin
                    wdata_d = alu;
                    state_d = WRITE;
                end
            end
            WRITE: if (i_mem_ack) begin
                res_valid_d = res_valid_q && (res_addr_q != addr_q);
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
        // Invalidation beats a coincident LR set.
        if (i_inval) res_valid_d = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            funct5_q    <= '0;
            addr_q      <= '0;
            rs2_q       <= '0;
            wdata_q     <= '0;
            result_q    <= '0;
            misal_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            funct5_q    <= funct5_d;
            addr_q      <= addr_d;
            rs2_q       <= rs2_d;
            wdata_q     <= wdata_d;
            result_q    <= result_d;
            misal_q     <= misal_d;
            res_valid_q <= res_valid_d;
            res_addr_q  <= res_addr_d;
        end
    end

    assign o_busy       = (state_q != IDLE) || i_req;
    assign o_done       = state_q == DONE;
    assign o_rd_data    = result_q;
    assign o_misaligned = o_done && misal_q;
    assign o_mem_req    = (state_q == READ) || (state_q == WRITE);
    assign o_mem_we     = state_q == WRITE;
    assign o_mem_addr   = {addr_q, 2'b00};
    assign o_mem_wdata  = wdata_q;
endmodule

// File: tb/tb_atomic_unit.sv
// tb_atomic_unit: directed checks of atomic_unit against a simple bench-side word memory.
module tb_atomic_unit;
    localparam logic [4:0] F_ADD  = 5'b00000;
    localparam logic [4:0] F_SWAP = 5'b00001;
    localparam logic [4:0] F_LR   = 5'b00010;
    localparam logic [4:0] F_SC   = 5'b00011;
    localparam logic [4:0] F_XOR  = 5'b00100;
    localparam logic [4:0] F_MIN  = 5'b10000;
    localparam logic [4:0] F_MINU = 5'b11000;

    logic        clk = 1'b0, rstn = 1'b1, req = 1'b0, inval = 1'b0, ack = 1'b0;
    logic [4:0]  f5 = '0;
    logic [31:0] addr = '0, rs2 = '0, rdata = '0;
    logic        o_busy, o_done, o_misaligned, o_mem_req, o_mem_we;
    logic [31:0] o_rd_data, o_mem_addr, o_mem_wdata;

    atomic_unit dut (
        .i_clk(clk), .i_rstn(rstn), .i_req(req), .i_funct5(f5), .i_addr(addr), .i_rs2(rs2),
        .i_inval(inval), .o_busy(o_busy), .o_done(o_done), .o_rd_data(o_rd_data),
        .o_misaligned(o_misaligned), .o_mem_req(o_mem_req), .o_mem_we(o_mem_we),
        .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .i_mem_ack(ack), .i_mem_rdata(rdata)
    );

    always #5 clk = ~clk;

    int          total = 0, bad = 0;
    logic [31:0] mem [0:1023];
    logic [31:0] rd_got, raddr_got, waddr_got, wdata_got;
    logic        mis_got, stable_ok;
    int          cyc, nreq, nwr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request and plays memory with a fixed number of wait cycles per access.
    task automatic run(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] d, input int waits);
        int          wc;
        logic        done;
        logic [31:0] ref_addr, ref_wd;
        logic        ref_we;
        wc = 0; done = 1'b0; cyc = 0; nreq = 0; nwr = 0; stable_ok = 1'b1; mis_got = 1'b0;
        rd_got = 'x; ref_addr = '0; ref_wd = '0; ref_we = 1'b0;
        @(negedge clk);
        f5 = fn; addr = a; rs2 = d; req = 1'b1;
        while (!done && cyc < 60) begin
            cyc++;
            ack = 1'b0;
            if (o_mem_req) begin
                nreq++;
                if (wc == 0) begin
                    ref_addr = o_mem_addr; ref_we = o_mem_we; ref_wd = o_mem_wdata;
                end else if (o_mem_addr !== ref_addr || o_mem_we !== ref_we || o_mem_wdata !== ref_wd) begin
                    stable_ok = 1'b0;
                end
                if (wc == waits) begin
                    ack = 1'b1; wc = 0;
                    if (o_mem_we) begin
                        mem[o_mem_addr[11:2]] = o_mem_wdata;
                        nwr++; waddr_got = o_mem_addr; wdata_got = o_mem_wdata;
                    end else begin
                        rdata = mem[o_mem_addr[11:2]]; raddr_got = o_mem_addr;
                    end
                end else begin
                    wc++;
                end
            end
            if (o_done) begin
                done = 1'b1; rd_got = o_rd_data; mis_got = o_misaligned;
            end
            @(negedge clk);
            req = 1'b0; ack = 1'b0;
        end
        chk("done_within_budget", {31'b0, done}, 32'd1);
    endtask

    initial begin
        int guard;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        #1 rstn = 1'b0;
        #10;
        chk("rst_ctrl", {27'b0, o_busy, o_done, o_misaligned, o_mem_req, o_mem_we}, 32'd0);
        chk("rst_addr", o_mem_addr, 32'd0);
        chk("rst_wdata", o_mem_wdata, 32'd0);
        chk("rst_rd", o_rd_data, 32'd0);
        @(negedge clk); rstn = 1'b1;

        mem[32'h40] = 32'd5;
        run(F_ADD, 32'h100, 32'd7, 0);
        chk("add_rd", rd_got, 32'd5);
        chk("add_cycles", cyc, 32'd4);
        chk("add_raddr", raddr_got, 32'h100);
        chk("add_waddr", waddr_got, 32'h100);
        chk("add_wdata", wdata_got, 32'd12);
        chk("add_mem", mem[32'h40], 32'd12);

        mem[32'hC0] = 32'hFFFF_FFFF;
        run(F_MIN, 32'h300, 32'd1, 0);
        chk("min_wdata", wdata_got, 32'hFFFF_FFFF);
        chk("min_rd", rd_got, 32'hFFFF_FFFF);
        mem[32'hC0] = 32'hFFFF_FFFF;
        run(F_MINU, 32'h300, 32'd1, 0);
        chk("minu_wdata", wdata_got, 32'd1);
        chk("minu_rd", rd_got, 32'hFFFF_FFFF);

        mem[32'h80] = 32'h55;
        run(F_LR, 32'h200, 32'd0, 0);
        chk("lr_rd", rd_got, 32'h55);
        chk("lr_cycles", cyc, 32'd3);
        chk("lr_nwr", nwr, 32'd0);
        run(F_SC, 32'h200, 32'hAA, 0);
        chk("sc_ok_rd", rd_got, 32'd0);
        chk("sc_ok_cycles", cyc, 32'd3);
        chk("sc_ok_waddr", waddr_got, 32'h200);
        chk("sc_ok_mem", mem[32'h80], 32'hAA);
        run(F_SC, 32'h200, 32'hBB, 0);
        chk("sc_again_rd", rd_got, 32'd1);
        chk("sc_again_cycles", cyc, 32'd2);
        chk("sc_again_nreq", nreq, 32'd0);

        run(F_LR, 32'h200, 32'd0, 0);
        chk("lr2_rd", rd_got, 32'hAA);
        run(F_SC, 32'h204, 32'hCC, 0);
        chk("sc_other_rd", rd_got, 32'd1);
        chk("sc_other_nreq", nreq, 32'd0);
        run(F_LR, 32'h200, 32'd0, 0);
        @(negedge clk); inval = 1'b1;
        @(negedge clk); inval = 1'b0;
        run(F_SC, 32'h200, 32'hDD, 0);
        chk("sc_inval_rd", rd_got, 32'd1);
        chk("sc_inval_nreq", nreq, 32'd0);
        chk("sc_inval_mem", mem[32'h80], 32'hAA);

        run(F_SWAP, 32'h102, 32'd9, 0);
        chk("misal_flag", {31'b0, mis_got}, 32'd1);
        chk("misal_cycles", cyc, 32'd2);
        chk("misal_nreq", nreq, 32'd0);

        mem[32'h100] = 32'hF0F0;
        run(F_XOR, 32'h400, 32'h0FF0, 3);
        chk("xor_cycles", cyc, 32'd10);
        chk("xor_rd", rd_got, 32'hF0F0);
        chk("xor_wdata", wdata_got, 32'hFF00);
        chk("xor_stable", {31'b0, stable_ok}, 32'd1);
        chk("xor_flag_clear", {31'b0, mis_got}, 32'd0);

        run(F_LR, 32'h200, 32'd0, 0);
        @(negedge clk);
        f5 = F_XOR; addr = 32'h404; rs2 = 32'd2; req = 1'b1;
        @(negedge clk); req = 1'b0;
        guard = 0;
        while (!(o_mem_req && o_mem_we) && guard < 20) begin
            ack = o_mem_req;
            @(negedge clk);
            ack = 1'b0;
            guard++;
        end
        chk("reached_write", {31'b0, o_mem_we}, 32'd1);
        #2 rstn = 1'b0;
        #1;
        chk("arst_ctrl", {27'b0, o_busy, o_done, o_misaligned, o_mem_req, o_mem_we}, 32'd0);
        chk("arst_addr", o_mem_addr, 32'd0);
        chk("arst_wdata", o_mem_wdata, 32'd0);
        chk("arst_rd", o_rd_data, 32'd0);
        @(negedge clk); rstn = 1'b1;
        run(F_SC, 32'h200, 32'hEE, 0);
        chk("sc_after_rst_rd", rd_got, 32'd1);
        chk("sc_after_rst_nreq", nreq, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
